// File: rtl/easyobv_axis_gen.sv
// AXI4-Stream traffic generator: fixed-length sequence-payload packets with idle gaps.
// Optional AXIS_GEN_TIMESTAMP_EN puts a time_cnt stamp on the first beat of each packet.
module easyobv_axis_gen #(
  parameter int DWIDTH    = 64,
  parameter int LEN_WIDTH = 16,
  parameter int GAP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic [31:0]           num_pkts,
  output logic [DWIDTH-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DWIDTH/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [63:0]           sent_pkt_cnt,
  output logic [63:0]           sent_beat_cnt,
  output logic [63:0]           time_cnt
);

  localparam int LANES = DWIDTH / 32;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_idx;
  logic [GAP_WIDTH-1:0] gap_q;
  logic [GAP_WIDTH-1:0] gap_cnt;
  logic [31:0]          num_q;
  logic [31:0]          pkt_cnt;
  logic [31:0]          beat_seq;
  logic                 tvalid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 stop_seen;
  logic [63:0]          pkt_total;
  logic [63:0]          beat_total;
  logic [63:0]          time_q;
  logic                 hs;
  logic                 last;

  assign hs   = tvalid_q & m_axis_tready;
  assign last = (beat_idx == len_q - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      beat_idx   <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      num_q      <= '0;
      pkt_cnt    <= '0;
      beat_seq   <= '0;
      tvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stop_seen  <= 1'b0;
      pkt_total  <= '0;
      beat_total <= '0;
      time_q     <= '0;
    end else begin
      time_q <= time_q + 64'd1;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // done_q gate: a start coinciding with the done pulse is dropped
          if (start && !done_q) begin
            len_q      <= (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
            gap_q      <= gap;
            num_q      <= num_pkts;
            beat_idx   <= '0;
            pkt_cnt    <= '0;
            beat_seq   <= '0;
            pkt_total  <= '0;
            beat_total <= '0;
            stop_seen  <= 1'b0;
            tvalid_q   <= 1'b1;
            busy_q     <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            beat_seq   <= beat_seq + 32'd1;
            beat_total <= beat_total + 64'd1;
            if (last) begin
              beat_idx  <= '0;
              pkt_cnt   <= pkt_cnt + 32'd1;
              pkt_total <= pkt_total + 64'd1;
              if ((num_q != '0 && pkt_cnt + 32'd1 == num_q) || stop) begin
                state    <= IDLE;
                tvalid_q <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end else if (gap_q != '0) begin
                state     <= GAP;
                gap_cnt   <= gap_q;
                tvalid_q  <= 1'b0;
                stop_seen <= 1'b0;
              end
            end else begin
              beat_idx <= beat_idx + LEN_WIDTH'(1);
            end
          end
        end
        GAP: begin
          stop_seen <= stop_seen | stop;
          if (gap_cnt == GAP_WIDTH'(1)) begin
            if (stop_seen || stop) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state    <= SEND;
              tvalid_q <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_GEN_TIMESTAMP_EN
  logic [63:0] ts_q;

  // Tracks time_cnt of the next cycle, frozen while a first beat waits
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else if (!(tvalid_q && beat_idx == '0 && !m_axis_tready)) begin
      ts_q <= time_q + 64'd1;
    end
  end
`endif

  always_comb begin
    m_axis_tdata = '0;
    if (tvalid_q) begin
      for (int i = 0; i < LANES; i++) begin
        m_axis_tdata[32*i +: 32] = beat_seq + 32'(i);
      end
`ifdef AXIS_GEN_TIMESTAMP_EN
      if (beat_idx == '0) begin
        m_axis_tdata[63:0] = ts_q;
      end
`endif
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q & last;
  assign m_axis_tkeep  = '1;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sent_pkt_cnt  = pkt_total;
  assign sent_beat_cnt = beat_total;
  assign time_cnt      = time_q;

endmodule

// File: tb/tb_easyobv_axis_gen.sv
// Directed self-checking bench for easyobv_axis_gen.
// Build with AXIS_GEN_TIMESTAMP_EN to run the timestamp scenario instead.
module tb_easyobv_axis_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] pkt_len;
  logic [15:0] gap;
  logic [31:0] num_pkts;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        busy;
  logic        done;
  logic [63:0] sent_pkt_cnt;
  logic [63:0] sent_beat_cnt;
  logic [63:0] time_cnt;

  int n_cmp = 0;
  int n_err = 0;

  easyobv_axis_gen #(.DWIDTH(64), .LEN_WIDTH(16), .GAP_WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .pkt_len       (pkt_len),
    .gap           (gap),
    .num_pkts      (num_pkts),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast),
    .busy          (busy),
    .done          (done),
    .sent_pkt_cnt  (sent_pkt_cnt),
    .sent_beat_cnt (sent_beat_cnt),
    .time_cnt      (time_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int len, input int g, input int n);
    pkt_len  = 16'(len);
    gap      = 16'(g);
    num_pkts = 32'(n);
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    int beats;
    int cyc;
    int last_t;
    logic prev_v;
    logic prev_stall;
    logic [63:0] prev_data;
    logic [31:0] exp_seq;
    logic saw_last;
    logic [63:0] ts;

    rst = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b0;
    pkt_len = '0; gap = '0; num_pkts = '0;
    step(); step();
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pkts", sent_pkt_cnt, 64'd0);
    chk("rst_beats", sent_beat_cnt, 64'd0);
    chk("rst_time", time_cnt, 64'd0);
    chk("tkeep", 64'(tkeep), 64'hff);
    rst = 1'b0;
    step();
    chk("time_run", time_cnt, 64'd1);

`ifndef AXIS_GEN_TIMESTAMP_EN
    // back-to-back: len 4, gap 0, 2 packets
    tready = 1'b1;
    go(4, 0, 2);
    chk("t1_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_valid", 64'(tvalid), 64'd1);
      chk("t1_lane0", 64'(tdata[31:0]), 64'(i));
      chk("t1_lane1", 64'(tdata[63:32]), 64'(i + 1));
      chk("t1_last", 64'(tlast), 64'((i % 4) == 3));
      chk("t1_sbeat", sent_beat_cnt, 64'(i));
      step();
    end
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_busy0", 64'(busy), 64'd0);
    chk("t1_valid0", 64'(tvalid), 64'd0);
    chk("t1_pkts", sent_pkt_cnt, 64'd2);
    chk("t1_beats", sent_beat_cnt, 64'd8);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_ign_busy", 64'(busy), 64'd0);
    chk("t1_ign_valid", 64'(tvalid), 64'd0);
    chk("t1_done_pulse", 64'(done), 64'd0);

    // gapped: len 3, gap 5, 3 packets
    go(3, 5, 3);
    beats = 0; cyc = 0; last_t = -1; prev_v = 1'b0;
    while (!done && cyc < 200) begin
      if (tvalid && !prev_v && last_t >= 0)
        chk("t2_gap", 64'(cyc - last_t - 1), 64'd5);
      if (tvalid && tready) begin
        chk("t2_lane0", 64'(tdata[31:0]), 64'(beats));
        beats++;
        if (tlast) last_t = cyc;
      end
      prev_v = tvalid;
      step();
      cyc++;
    end
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_beats", 64'(beats), 64'd9);
    chk("t2_pkts", sent_pkt_cnt, 64'd3);
    chk("t2_sbeats", sent_beat_cnt, 64'd9);

    // random backpressure: len 16, 10 packets
    step();
    go(16, 0, 10);
    beats = 0; cyc = 0; exp_seq = '0; prev_stall = 1'b0; prev_data = '0;
    while (!done && cyc < 2000) begin
      tready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        chk("t3_hold_v", 64'(tvalid), 64'd1);
        chk("t3_hold_d", tdata, prev_data);
      end
      if (tvalid && tready) begin
        chk("t3_lane0", 64'(tdata[31:0]), 64'(exp_seq));
        chk("t3_lane1", 64'(tdata[63:32]), 64'(exp_seq + 32'd1));
        chk("t3_last", 64'(tlast), 64'((beats % 16) == 15));
        exp_seq = exp_seq + 32'd1;
        beats++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      step();
      cyc++;
    end
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_beats", 64'(beats), 64'd160);
    chk("t3_sbeats", sent_beat_cnt, 64'd160);
    chk("t3_pkts", sent_pkt_cnt, 64'd10);

    // endless run stopped on 3rd beat of packet 5
    tready = 1'b1;
    step();
    go(8, 0, 0);
    beats = 0; cyc = 0; saw_last = 1'b0;
    while (!done && cyc < 500) begin
      if (tvalid && tready) begin
        if (beats == 34) stop = 1'b1;
        saw_last = tlast;
        beats++;
      end
      step();
      cyc++;
    end
    stop = 1'b0;
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_beats", 64'(beats), 64'd40);
    chk("t4_lastbeat", 64'(saw_last), 64'd1);
    chk("t4_pkts", sent_pkt_cnt, 64'd5);

    // stop raised briefly inside a gap
    step();
    go(2, 4, 0);
    chk("t5_b0", 64'(tlast), 64'd0);
    step();
    chk("t5_b1_last", 64'(tlast), 64'd1);
    step();
    chk("t5_gap_v", 64'(tvalid), 64'd0);
    chk("t5_gap_busy", 64'(busy), 64'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(); step(); step();
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_valid", 64'(tvalid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_pkts", sent_pkt_cnt, 64'd1);

    // reset mid-packet after 2 of 6 beats
    step();
    go(6, 0, 1);
    step(); step();
    chk("t6_mid_v", 64'(tvalid), 64'd1);
    chk("t6_mid_lane0", 64'(tdata[31:0]), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid", 64'(tvalid), 64'd0);
    chk("t6_last", 64'(tlast), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_beats", sent_beat_cnt, 64'd0);
    chk("t6_time", time_cnt, 64'd0);
    go(6, 0, 1);
    chk("t6_re_v", 64'(tvalid), 64'd1);
    chk("t6_re_lane0", 64'(tdata[31:0]), 64'd0);
    cyc = 0;
    while (!done && cyc < 50) begin
      step();
      cyc++;
    end
    chk("t6_re_done", 64'(done), 64'd1);
    chk("t6_re_beats", sent_beat_cnt, 64'd6);
`else
    // first-beat timestamp held through a 3-cycle stall
    tready = 1'b0;
    go(2, 0, 1);
    chk("ts_valid", 64'(tvalid), 64'd1);
    ts = time_cnt;
    for (int i = 0; i < 3; i++) begin
      chk("ts_hold", tdata, ts);
      step();
    end
    tready = 1'b1;
    chk("ts_accept", tdata, ts);
    step();
    chk("ts_beat1", 64'(tdata[31:0]), 64'd1);
    chk("ts_beat1_l1", 64'(tdata[63:32]), 64'd2);
    step();
    chk("ts_done", 64'(done), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
